// File: rtl/handshake_arbiter.sv
`default_nettype none
// handshake_arbiter: round-robin merge of N_REQ four-phase requesters onto one
// four-phase downstream port. All outputs are registered.
module handshake_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_in,
  input  logic [N_REQ*DATA_W-1:0]    data_in,
  output logic [N_REQ-1:0]           ack_in,
  output logic                       req_out,
  input  logic                       ack_out,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(N_REQ)-1:0]   grant,
  output logic                       busy,
  output logic [7:0]                 txn_count,
  output logic                       err
);

  localparam int GW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_RTZ  = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [GW-1:0]     ptr_q,     ptr_d;
  logic [GW-1:0]     grant_q,   grant_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic              req_out_q, req_out_d;
  logic [N_REQ-1:0]  ack_in_q,  ack_in_d;
  logic              busy_q,    busy_d;
  logic [7:0]        txn_q,     txn_d;
  logic              err_q,     err_d;

  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  logic [GW-1:0]     cand;
  logic [DATA_W-1:0] data_sel;

  // Rotating priority search: first asserted request at or above ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = GW'((int'(ptr_q) + k) % N_REQ);
      if (!pick_found && req_in[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    data_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == GW'(i)) data_sel = data_in[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      req_out_q <= 1'b0;
      ack_in_q  <= '0;
      busy_q    <= 1'b0;
      txn_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      req_out_q <= req_out_d;
      ack_in_q  <= ack_in_d;
      busy_q    <= busy_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_found)       state_d = S_REQ;
      S_REQ:   if (ack_out)          state_d = S_HOLD;
      S_HOLD:  if (!req_in[grant_q]) state_d = S_RTZ;
      S_RTZ:   if (!ack_out)         state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    req_out_d = req_out_q;
    ack_in_d  = ack_in_q;
    txn_d     = txn_q;
    err_d     = err_q;
    busy_d    = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (ack_out) err_d = 1'b1;
        if (pick_found) begin
          grant_d   = pick_idx;
          data_d    = data_sel;
          req_out_d = 1'b1;
        end
      end
      S_REQ: begin
        // A withdrawn request is flagged but the handshake still completes.
        if (!req_in[grant_q]) err_d = 1'b1;
        if (ack_out) begin
          ack_in_d          = '0;
          ack_in_d[grant_q] = 1'b1;
        end
      end
      S_HOLD: begin
        if (!req_in[grant_q]) req_out_d = 1'b0;
      end
      S_RTZ: begin
        if (!ack_out) begin
          ack_in_d = '0;
          txn_d    = txn_q + 8'd1;
          ptr_d    = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
        end
      end
      default: ;
    endcase
  end

  assign ack_in    = ack_in_q;
  assign req_out   = req_out_q;
  assign data_out  = data_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign txn_count = txn_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_arbiter.sv
`default_nettype none
// tb_handshake_arbiter: directed scenarios plus randomized transactions checked
// against a transaction-level round-robin model.
module tb_handshake_arbiter;

  localparam int N  = 4;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]  ack_in;
  logic          req_out;
  logic          ack_out;
  logic [DW-1:0] data_out;
  logic [1:0]    grant;
  logic          busy;
  logic [7:0]    txn_count;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model state
  int   m_ptr;
  int   m_cnt;
  logic m_err;

  always #5 clk = ~clk;

  handshake_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .data_in(data_in), .ack_in(ack_in),
    .req_out(req_out), .ack_out(ack_out), .data_out(data_out), .grant(grant),
    .busy(busy), .txn_count(txn_count), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (((m >> i) & 1) != 0) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    return N'(1 << g);
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_out"}, req_out, 0);
    chk({tag, "_ack_in"}, ack_in, 0);
    chk({tag, "_data_out"}, data_out, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_txn"}, txn_count, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // One full four-phase transaction with the bench playing both partners.
  task automatic run_txn(input logic [N-1:0] mask, input logic [N*DW-1:0] data,
                         input int stall, input int hold, input int rz);
    int g;
    logic [DW-1:0] d;
    g = pick(mask, m_ptr);
    d = DW'(data >> (g * DW));
    req_in  = mask;
    data_in = data;
    ack_out = 1'b0;
    step();
    chk("grant", grant, g);
    chk("data_out", data_out, d);
    chk("req_out_up", req_out, 1);
    chk("busy_up", busy, 1);
    chk("ack_in_req", ack_in, 0);
    data_in = N*DW'($urandom);
    req_in  = N'($urandom) | onehot(g);
    repeat (stall) begin
      step();
      chk("stall_req_out", req_out, 1);
      chk("stall_data", data_out, d);
      chk("stall_grant", grant, g);
      chk("stall_ack_in", ack_in, 0);
      chk("stall_busy", busy, 1);
    end
    ack_out = 1'b1;
    step();
    chk("ack_in_set", ack_in, onehot(g));
    chk("req_out_hold", req_out, 1);
    repeat (hold) begin
      req_in = N'($urandom) | onehot(g);
      step();
      chk("hold_ack_in", ack_in, onehot(g));
      chk("hold_req_out", req_out, 1);
    end
    req_in = N'($urandom) & ~onehot(g);
    step();
    chk("req_out_rtz", req_out, 0);
    chk("rtz_ack_in", ack_in, onehot(g));
    repeat (rz) begin
      step();
      chk("rtz_wait_ack_in", ack_in, onehot(g));
      chk("rtz_wait_txn", txn_count, m_cnt);
    end
    ack_out = 1'b0;
    req_in  = '0;
    step();
    m_cnt = (m_cnt + 1) % 256;
    m_ptr = (g + 1) % N;
    chk("ack_in_clr", ack_in, 0);
    chk("txn_count", txn_count, m_cnt);
    chk("busy_down", busy, 0);
    chk("grant_stable", grant, g);
    chk("err", err, m_err);
  endtask

  initial begin
    rst = 1'b1; req_in = '0; data_in = '0; ack_out = 1'b0;
    model_reset();
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b0;

    // Single request, channel 0 with payload 2'b10
    run_txn(4'b0001, 8'b0000_0010, 0, 0, 0);
    chk("single_data", data_out, 2'b10);

    // Contention: all four held, expect 1,2,3,0,1 after the single txn moved ptr to 1
    repeat (5) run_txn(4'b1111, N*DW'($urandom), 0, 0, 0);

    // Pointer wrap: serve 3, then 1001 must go to 0
    run_txn(4'b1000, N*DW'($urandom), 0, 0, 0);
    run_txn(4'b1001, N*DW'($urandom), 0, 0, 0);
    chk("wrap_grant", grant, 0);

    // Stall for 10 cycles in REQ
    run_txn(4'b0100, N*DW'($urandom), 10, 0, 0);

    // Protocol error: ack_out high in IDLE
    chk("err_pre", err, 0);
    ack_out = 1'b1;
    step();
    m_err = 1'b1;
    chk("err_idle_ack", err, 1);
    chk("err_busy", busy, 0);
    ack_out = 1'b0;
    step();
    chk("err_sticky", err, 1);
    run_txn(4'b0010, N*DW'($urandom), 1, 1, 1);
    chk("err_after_good", err, 1);

    // Reset clears everything including err
    rst = 1'b1;
    step();
    model_reset();
    chk_all_zero("reset2");
    rst = 1'b0;

    // Withdrawn request in REQ raises err; handshake still completes
    req_in = 4'b0001; data_in = 8'h03;
    step();
    chk("wd_grant", grant, 0);
    req_in = 4'b0000;
    step();
    chk("wd_err", err, 1);
    chk("wd_req_out", req_out, 1);
    ack_out = 1'b1;
    step();
    chk("wd_ack_in", ack_in, 4'b0001);
    step();
    chk("wd_rtz", req_out, 0);
    ack_out = 1'b0;
    step();
    chk("wd_txn", txn_count, 1);
    chk("wd_ack_clr", ack_in, 0);

    // Mid-transaction reset in HOLD
    rst = 1'b1;
    step();
    model_reset();
    rst = 1'b0;
    req_in = 4'b0010; data_in = N*DW'($urandom);
    step();
    ack_out = 1'b1;
    step();
    chk("mid_hold_ack", ack_in, 4'b0010);
    rst = 1'b1; ack_out = 1'b0; req_in = '0;
    step();
    chk_all_zero("mid_reset");
    rst = 1'b0;
    run_txn(4'b0110, N*DW'($urandom), 0, 0, 0);
    chk("mid_next_grant", grant, 1);

    // Randomized traffic; enough transactions to wrap txn_count
    for (int t = 0; t < 300; t++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      run_txn(m, N*DW'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
              $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("idle_busy", busy, 0);
        chk("idle_req_out", req_out, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
